// File: rtl/bus_mux_if.sv
// Shared-channel bundle between the arbiter/timer stage, the requesting
// ports and the bus_mux data-path stage.
interface bus_mux_if #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_WIDTH = 2,
  parameter int CNT_WIDTH  = 8
);
  logic [0:NUM_PORTS-1]            grant;
  logic                            active;
  logic [0:NUM_PORTS-1]            in_valid;
  logic [0:NUM_PORTS-1]            in_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [PORT_WIDTH-1:0]           out_port;
  logic                            busy;
  logic                            tenure_done;
  logic [CNT_WIDTH-1:0]            beat_count;
  logic                            grant_err;

  // Environment side: arbiter, requesting ports and channel sink.
  modport master (
    output grant, active, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_port, busy, tenure_done,
           beat_count, grant_err
  );

  // Mux side.
  modport slave (
    input  grant, active, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_port, busy, tenure_done,
           beat_count, grant_err
  );
endinterface

// File: rtl/bus_mux.sv
// bus_mux: routes the granted port's valid/ready stream onto one shared
// channel through a one-entry output register, and counts beats per tenure.
module bus_mux #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_WIDTH = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic      clk,
  input logic      rst,
  bus_mux_if.slave bus
);
  // state | meaning
  // IDLE  | no owner; waiting for a clean one-hot grant
  // OWN   | owner latched; owner's beats flow into the output register
  // DRAIN | grant withdrawn; waiting for the buffered beat to leave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PORT_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_WIDTH-1:0]  run_cnt_q;
  logic [CNT_WIDTH-1:0]  beat_count_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [PORT_WIDTH-1:0] out_port_q;

  logic [0:NUM_PORTS-1]  owner_mask;
  logic [0:NUM_PORTS-1]  in_ready_c;
  logic [PORT_WIDTH-1:0] grant_idx;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_granted;
  logic                  owner_valid;
  logic                  extra_grant;
  logic                  room;
  logic                  accept;
  logic                  claim;
  logic                  finish;
  logic                  grant_err_c;

  // Decode the incoming grant and select the current owner's lanes.
  always_comb begin
    grant_idx  = '0;
    owner_mask = '0;
    owner_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.grant[i]) grant_idx = PORT_WIDTH'(i);
      owner_mask[i] = (owner_q == PORT_WIDTH'(i));
      if (owner_q == PORT_WIDTH'(i)) owner_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A drop of either the owner's grant bit or active ends the tenure and
  // blocks any transfer in that same cycle.
  assign owner_granted = |(bus.grant & owner_mask) & bus.active;
  assign owner_valid   = |(bus.in_valid & owner_mask);
  assign extra_grant   = |(bus.grant & ~owner_mask);
  assign room          = ~out_valid_q | bus.out_ready;

  // Next-state, handshake and pulse decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    in_ready_c  = '0;
    accept      = 1'b0;
    claim       = 1'b0;
    finish      = 1'b0;
    grant_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.active) begin
          if ($onehot(bus.grant)) begin
            claim   = 1'b1;
            owner_d = grant_idx;
            state_d = OWN;
          end else begin
            grant_err_c = 1'b1;
          end
        end
      end
      OWN: begin
        grant_err_c = extra_grant;
        if (owner_granted) begin
          if (room) in_ready_c = owner_mask;
          accept = room & owner_valid;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (room) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Output register and per-tenure beat accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      run_cnt_q    <= '0;
      beat_count_q <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= owner_data;
        out_port_q  <= owner_q;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (claim) begin
        run_cnt_q <= '0;
      end else if (accept && (run_cnt_q != '1)) begin
        run_cnt_q <= run_cnt_q + 1'b1;
      end
      if (finish) beat_count_q <= run_cnt_q;
    end
  end

  // Combinational handshakes and pulses stay quiet while reset is held.
  assign bus.in_ready    = rst ? '0 : in_ready_c;
  assign bus.grant_err   = ~rst & grant_err_c;
  assign bus.tenure_done = ~rst & finish;
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_port    = out_port_q;
  assign bus.beat_count  = beat_count_q;
endmodule

// File: tb/tb_bus_mux.sv
// Bench for bus_mux: directed scenarios plus a randomized run against a
// transaction-level reference model. Two DUTs share stimulus; the second
// uses a 2-bit beat counter to exercise saturation.
module tb_bus_mux;
  localparam int NP = 3;
  localparam int DW = 32;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .CNT_WIDTH(8)) ai ();
  bus_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .CNT_WIDTH(2)) bi ();

  assign bi.grant     = ai.grant;
  assign bi.active    = ai.active;
  assign bi.in_valid  = ai.in_valid;
  assign bi.in_data   = ai.in_data;
  assign bi.out_ready = ai.out_ready;

  bus_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(ai)
  );
  bus_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bi)
  );

  task automatic set_data(input int p, input logic [DW-1:0] d);
    ai.in_data[p*DW +: DW] = d;
  endtask

  task automatic wait_tenure(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk); #1;
      if (ai.tenure_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    rst = 1'b1;
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0; ai.in_data = '0; ai.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      obs = {ai.out_valid, ai.out_data, ai.out_port, ai.in_ready, ai.busy,
             ai.tenure_done, ai.beat_count, ai.grant_err};
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
      end
      vectors++;
      if ({bi.busy, bi.beat_count, bi.out_valid} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_sat cycle %0d: got %b expected 0", c, {bi.busy, bi.beat_count, bi.out_valid});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_burst();
    bit seen;
    @(negedge clk);
    ai.grant = 3'b010; ai.active = 1'b1; ai.in_valid = 3'b010; ai.out_ready = 1'b1;
    set_data(1, 32'hA0);
    #1;
    vectors++;
    if (ai.in_ready !== 3'b000 || ai.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_grant_cycle: in_ready %b busy %b expected 000 0", ai.in_ready, ai.busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_data(1, 32'hA0 + k);
      #1;
      vectors++;
      if (ai.in_ready !== 3'b010) begin
        miscompares++;
        $display("FAIL burst_in_ready beat %0d: got %b expected 010", k, ai.in_ready);
      end
      vectors++;
      if (ai.out_valid !== (k > 0)) begin
        miscompares++;
        $display("FAIL burst_out_valid beat %0d: got %b expected %b", k, ai.out_valid, (k > 0));
      end
      if (k > 0) begin
        vectors++;
        if (ai.out_data !== 32'hA0 + k - 1 || ai.out_port !== 2'd1) begin
          miscompares++;
          $display("FAIL burst_out_data beat %0d: got %h/%0d expected %h/1", k, ai.out_data, ai.out_port, 32'hA0 + k - 1);
        end
      end
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0;
    #1;
    vectors++;
    if (ai.in_ready !== 3'b000 || ai.out_valid !== 1'b1 || ai.out_data !== 32'hA3) begin
      miscompares++;
      $display("FAIL burst_last: in_ready %b valid %b data %h expected 000 1 a3", ai.in_ready, ai.out_valid, ai.out_data);
    end
    wait_tenure(seen);
    vectors++;
    if (!seen || ai.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_tenure: seen %b out_valid %b expected 1 0", seen, ai.out_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (ai.beat_count !== 8'd4 || bi.beat_count !== 2'd3 || ai.busy !== 1'b0 || ai.tenure_done !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_count: got %0d/%0d busy %b td %b expected 4/3 0 0", ai.beat_count, bi.beat_count, ai.busy, ai.tenure_done);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    logic [DW-1:0] held_data = '0;
    logic          held = 1'b0;
    int            sent = 0;
    int            stalls = 0;
    bit            seen;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      ai.grant = 3'b010; ai.active = 1'b1;
      ai.in_valid = (sent < 4) ? 3'b010 : 3'b000;
      set_data(1, 32'hB0 + sent);
      ai.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (held) begin
        vectors++;
        if (ai.out_valid !== 1'b1 || ai.out_data !== held_data) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got %b/%h expected 1/%h", c, ai.out_valid, ai.out_data, held_data);
        end
      end
      if (ai.out_valid && !ai.out_ready) begin
        stalls++;
        vectors++;
        if (ai.in_ready !== 3'b000) begin
          miscompares++;
          $display("FAIL bp_ready_full cycle %0d: got %b expected 000", c, ai.in_ready);
        end
      end
      held      = ai.out_valid && !ai.out_ready;
      held_data = ai.out_data;
      if (ai.out_valid && ai.out_ready) got.push_back(ai.out_data);
      if (ai.in_valid[1] && ai.in_ready[1]) sent++;
    end
    vectors++;
    if (stalls != 3) begin
      miscompares++;
      $display("FAIL bp_stalls: got %0d expected 3", stalls);
    end
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL bp_beat_total: got %0d expected 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 32'hB0 + i) begin
        miscompares++;
        $display("FAIL bp_order beat %0d: got %h expected %h", i, got[i], 32'hB0 + i);
      end
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0; ai.out_ready = 1'b1;
    wait_tenure(seen);
    @(negedge clk); #1;
    vectors++;
    if (!seen || ai.beat_count !== 8'd4) begin
      miscompares++;
      $display("FAIL bp_count: seen %b count %0d expected 1 4", seen, ai.beat_count);
    end
  endtask

  task automatic test_drain_hold();
    bit seen;
    @(negedge clk);
    ai.grant = 3'b001; ai.active = 1'b1; ai.in_valid = 3'b001; ai.out_ready = 1'b0;
    set_data(2, 32'hC5);
    @(negedge clk); #1;
    vectors++;
    if (ai.in_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL drain_accept: got %b expected 001", ai.in_ready);
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0;
    #1;
    vectors++;
    if (ai.in_ready !== 3'b000 || ai.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_drop: in_ready %b valid %b expected 000 1", ai.in_ready, ai.out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) begin ai.grant = 3'b010; ai.active = 1'b1; ai.in_valid = 3'b010; end
      #1;
      vectors++;
      if ({ai.busy, ai.tenure_done, ai.in_ready, ai.out_valid, ai.grant_err} !== 7'b1_0_000_1_0 ||
          ai.out_data !== 32'hC5 || ai.out_port !== 2'd2) begin
        miscompares++;
        $display("FAIL drain_hold cycle %0d: got %b %h %0d expected 1000010 c5 2", c,
                 {ai.busy, ai.tenure_done, ai.in_ready, ai.out_valid, ai.grant_err}, ai.out_data, ai.out_port);
      end
    end
    @(negedge clk);
    ai.out_ready = 1'b1;
    #1;
    vectors++;
    if (ai.tenure_done !== 1'b1 || ai.in_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL drain_release: td %b in_ready %b expected 1 000", ai.tenure_done, ai.in_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if ({ai.busy, ai.tenure_done, ai.out_valid, ai.in_ready} !== 6'b0 || ai.beat_count !== 8'd1) begin
      miscompares++;
      $display("FAIL drain_idle: got %b count %0d expected 000000 1",
               {ai.busy, ai.tenure_done, ai.out_valid, ai.in_ready}, ai.beat_count);
    end
    ai.in_valid = '0;
    @(negedge clk); #1;
    vectors++;
    if (ai.busy !== 1'b1 || ai.in_ready !== 3'b010) begin
      miscompares++;
      $display("FAIL regrant: busy %b in_ready %b expected 1 010", ai.busy, ai.in_ready);
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0;
    wait_tenure(seen);
    @(negedge clk); #1;
    vectors++;
    if (!seen || ai.beat_count !== 8'd0) begin
      miscompares++;
      $display("FAIL regrant_empty_count: seen %b count %0d expected 1 0", seen, ai.beat_count);
    end
  endtask

  task automatic test_grant_err();
    bit seen;
    @(negedge clk);
    ai.grant = 3'b110; ai.active = 1'b1; ai.in_valid = 3'b111; ai.out_ready = 1'b1;
    #1;
    vectors++;
    if (ai.grant_err !== 1'b1 || ai.in_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL err_idle_multi: err %b in_ready %b expected 1 000", ai.grant_err, ai.in_ready);
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0;
    #1;
    vectors++;
    if (ai.grant_err !== 1'b0 || ai.busy !== 1'b0 || ai.in_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL err_idle_after: err %b busy %b in_ready %b expected 0 0 000", ai.grant_err, ai.busy, ai.in_ready);
    end
    @(negedge clk);
    ai.grant = 3'b100; ai.active = 1'b1; ai.in_valid = 3'b100;
    set_data(0, 32'hD0);
    #1;
    vectors++;
    if (ai.grant_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean_grant: got %b expected 0", ai.grant_err);
    end
    @(negedge clk);
    ai.grant = 3'b101;
    #1;
    vectors++;
    if (ai.grant_err !== 1'b1 || ai.in_ready !== 3'b100 || ai.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_own_extra: err %b in_ready %b busy %b expected 1 100 1", ai.grant_err, ai.in_ready, ai.busy);
    end
    @(negedge clk);
    ai.grant = 3'b100; ai.in_valid = '0;
    #1;
    vectors++;
    if (ai.grant_err !== 1'b0 || ai.out_valid !== 1'b1 || ai.out_port !== 2'd0 || ai.out_data !== 32'hD0) begin
      miscompares++;
      $display("FAIL err_owner_kept: err %b valid %b port %0d data %h expected 0 1 0 d0",
               ai.grant_err, ai.out_valid, ai.out_port, ai.out_data);
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0;
    wait_tenure(seen);
    @(negedge clk); #1;
    vectors++;
    if (!seen || ai.beat_count !== 8'd1) begin
      miscompares++;
      $display("FAIL err_count: seen %b count %0d expected 1 1", seen, ai.beat_count);
    end
  endtask

  task automatic test_saturate();
    int sent = 0;
    bit seen;
    for (int c = 0; c < 30 && sent < 6; c++) begin
      @(negedge clk);
      ai.grant = 3'b100; ai.active = 1'b1; ai.in_valid = 3'b100; ai.out_ready = 1'b1;
      set_data(0, 32'hE0 + sent);
      #1;
      if (ai.in_ready[0] === 1'b1) sent++;
    end
    @(negedge clk);
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0;
    wait_tenure(seen);
    @(negedge clk); #1;
    vectors++;
    if (!seen || sent != 6 || ai.beat_count !== 8'd6 || bi.beat_count !== 2'd3) begin
      miscompares++;
      $display("FAIL saturate: seen %b sent %0d count %0d/%0d expected 1 6 6/3", seen, sent, ai.beat_count, bi.beat_count);
    end
  endtask

  task automatic test_random();
    int            m_owner = -1;
    bit            m_drain = 1'b0;
    int            m_run = 0;
    int            m_beats = 0;
    int            q_port[$];
    logic [DW-1:0] q_data[$];
    logic [0:NP-1] g = '0;
    logic          act = 1'b0;
    logic [0:NP-1] e_ir;
    logic [0:NP-1] others;
    logic          e_rdy, e_gerr, e_td;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(7))
          0: begin g = '0; act = 1'b0; end
          1: begin g = '1; g[$urandom_range(NP-1)] = 1'($urandom_range(1)); act = 1'b1; end
          2: begin g = '0; act = 1'b1; end
          default: begin g = '0; g[$urandom_range(NP-1)] = 1'b1; act = 1'b1; end
        endcase
      end
      ai.grant  = g;
      ai.active = ($urandom_range(19) == 0) ? ~act : act;
      for (int p = 0; p < NP; p++) ai.in_valid[p] = ($urandom_range(9) < 7);
      ai.in_data   = {$urandom, $urandom, $urandom};
      ai.out_ready = ($urandom_range(9) < 6);
      rst          = (c == 0) || ($urandom_range(299) == 0);
      #1;
      if (rst) begin
        m_owner = -1; m_drain = 1'b0; m_run = 0; m_beats = 0;
        q_port.delete(); q_data.delete();
        continue;
      end
      e_ir = '0; e_rdy = 1'b0; e_gerr = 1'b0; e_td = 1'b0;
      if (m_owner < 0) begin
        e_gerr = ai.active && ($countones(ai.grant) != 1);
      end else if (!m_drain) begin
        e_rdy = (q_data.size() == 0 || ai.out_ready) && ai.grant[m_owner] && ai.active;
        e_ir[m_owner] = e_rdy;
        others = ai.grant;
        others[m_owner] = 1'b0;
        e_gerr = |others;
      end else begin
        e_td = (q_data.size() == 0) || ai.out_ready;
      end
      vectors++;
      if (ai.in_ready !== e_ir) begin
        miscompares++;
        $display("FAIL rand_in_ready cycle %0d: got %b expected %b", c, ai.in_ready, e_ir);
      end
      vectors++;
      if (ai.grant_err !== e_gerr) begin
        miscompares++;
        $display("FAIL rand_grant_err cycle %0d: got %b expected %b", c, ai.grant_err, e_gerr);
      end
      vectors++;
      if (ai.tenure_done !== e_td) begin
        miscompares++;
        $display("FAIL rand_tenure_done cycle %0d: got %b expected %b", c, ai.tenure_done, e_td);
      end
      vectors++;
      if (ai.out_valid !== (q_data.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_out_valid cycle %0d: got %b expected %b", c, ai.out_valid, (q_data.size() != 0));
      end
      if (q_data.size() != 0) begin
        vectors++;
        if (ai.out_data !== q_data[0] || ai.out_port !== PW'(q_port[0])) begin
          miscompares++;
          $display("FAIL rand_out_data cycle %0d: got %h/%0d expected %h/%0d", c, ai.out_data, ai.out_port, q_data[0], q_port[0]);
        end
      end
      vectors++;
      if (ai.busy !== (m_owner >= 0)) begin
        miscompares++;
        $display("FAIL rand_busy cycle %0d: got %b expected %b", c, ai.busy, (m_owner >= 0));
      end
      vectors++;
      if (ai.beat_count !== 8'((m_beats > 255) ? 255 : m_beats) ||
          bi.beat_count !== 2'((m_beats > 3) ? 3 : m_beats)) begin
        miscompares++;
        $display("FAIL rand_beat_count cycle %0d: got %0d/%0d expected %0d (saturating 255/3)", c, ai.beat_count, bi.beat_count, m_beats);
      end
      if (q_data.size() != 0 && ai.out_ready) begin
        void'(q_data.pop_front());
        void'(q_port.pop_front());
      end
      if (e_rdy && ai.in_valid[m_owner]) begin
        q_data.push_back(ai.in_data[m_owner*DW +: DW]);
        q_port.push_back(m_owner);
        m_run++;
      end
      if (m_owner < 0) begin
        if (ai.active && $countones(ai.grant) == 1) begin
          for (int p = 0; p < NP; p++) if (ai.grant[p]) m_owner = p;
          m_run = 0;
        end
      end else if (!m_drain) begin
        if (!ai.grant[m_owner] || !ai.active) m_drain = 1'b1;
      end else if (e_td) begin
        m_beats = m_run;
        m_owner = -1;
        m_drain = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    ai.grant = '0; ai.active = 1'b0; ai.in_valid = '0; ai.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_drain_hold();
    test_grant_err();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end
endmodule
